mcu_wb_debug_ctrl: RTL and testbench

- Parametrised Wishbone control/debug unit for the 4-bit MCU cores (tms1x00 family and wider derivatives); sits between the Caravel Wishbone bus, the pad inputs and one core instance.
- Generalises the existing override/reset/step scheme with:
  - parametrised K/O/R/ROM widths;
  - a multi-cycle step counter;
  - a ROM-address breakpoint;
  - a run-cycle counter;
  - a configurable ack latency.
- Core clock is gated through core_run_o; the core runs on wb_clk_i.

---
 rtl/mcu_dbg_pkg.sv | 24 ++
 rtl/wb_ack_delay.sv | 33 +++
 rtl/mcu_wb_debug_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mcu_wb_debug_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_dbg_pkg.sv
// Shared register map and bit positions for the MCU Wishbone debug controller.
package mcu_dbg_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STEP   = 3'd1;
    localparam logic [2:0] REG_BRK    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_OUT    = 3'd4;
    localparam logic [2:0] REG_CYC    = 3'd5;

    localparam int CTRL_OVR    = 0;
    localparam int CTRL_CRST   = 1;
    localparam int CTRL_RUN    = 2;
    localparam int CTRL_CS     = 3;
    localparam int CTRL_K_LSB  = 8;

    localparam int STAT_HALTED   = 0;
    localparam int STAT_BRK_HIT  = 1;
    localparam int STAT_STEP_LSB = 8;

    localparam int BRK_EN_BIT  = 31;
    localparam int SEL_ADR_BIT = 23;

endpackage

// File: rtl/wb_ack_delay.sv
// Accept gating and fixed-latency ack: one token walks an ACK_LAT-stage shift
// register; the block stays busy until the token leaves the last stage.
module wb_ack_delay #(
    parameter int ACK_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic accept_o,
    output logic ack_o
);

    logic [ACK_LAT-1:0] sr_q;
    logic [ACK_LAT-1:0] sr_d;
    logic               pending;

    assign pending  = |sr_q;
    assign accept_o = req_i & ~pending;
    assign ack_o    = sr_q[ACK_LAT-1];

    always_comb begin
        sr_d = (sr_q << 1) | ACK_LAT'(accept_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/mcu_wb_debug_ctrl.sv
// Wishbone control/debug unit for a 4-bit MCU core: pad overrides, core reset,
// run gating with step counter and ROM breakpoint, and a run-cycle counter.
module mcu_wb_debug_ctrl
    import mcu_dbg_pkg::*;
#(
    parameter int K_W     = 4,
    parameter int O_W     = 8,
    parameter int R_W     = 16,
    parameter int ROM_AW  = 11,
    parameter int STEP_W  = 16,
    parameter int ACK_LAT = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic              pad_chip_sel_i,
    input  logic [K_W-1:0]    pad_k_i,
    input  logic [O_W-1:0]    core_o_i,
    input  logic [R_W-1:0]    core_r_i,
    input  logic [ROM_AW-1:0] core_pc_i,
    input  logic              core_fetch_i,
    output logic              core_rst_o,
    output logic              core_run_o,
    output logic              core_chip_sel_o,
    output logic [K_W-1:0]    core_k_o,
    output logic              dbg_halted_o
);

    logic              ovr_q, ovr_d;
    logic              crst_q, crst_d;
    logic              run_q, run_d;
    logic              cs_q, cs_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [ROM_AW-1:0] brk_addr_q, brk_addr_d;
    logic              brk_en_q, brk_en_d;
    logic              brk_hit_q, brk_hit_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       dat_q, dat_d;

    logic        bus_req;
    logic        accept;
    logic        wr;
    logic [2:0]  off;
    logic [31:0] rdata;
    logic        step_nz;
    logic        brk_match;
    logic        unused_bus;

    assign bus_req    = wbs_cyc_i & wbs_stb_i & wbs_adr_i[SEL_ADR_BIT];
    assign wr         = accept & wbs_we_i;
    assign off        = wbs_adr_i[4:2];
    assign unused_bus = ^{wbs_adr_i, wbs_dat_i};

    wb_ack_delay #(
        .ACK_LAT (ACK_LAT)
    ) u_ack_delay (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .req_i    (bus_req),
        .accept_o (accept),
        .ack_o    (wbs_ack_o)
    );

    // The reset term is combinational so the core is held the instant reset asserts.
    assign core_rst_o      = ~wb_rst_ni | (ovr_q & crst_q);
    assign step_nz         = |step_q;
    assign core_run_o      = ~core_rst_o & ~brk_hit_q & (~ovr_q | run_q | step_nz);
    assign dbg_halted_o    = ~core_run_o & ~core_rst_o;
    assign core_chip_sel_o = ovr_q ? cs_q : pad_chip_sel_i;
    assign core_k_o        = ovr_q ? k_q : pad_k_i;
    assign wbs_dat_o       = dat_q;

    assign brk_match = core_run_o & core_fetch_i & brk_en_q & (core_pc_i == brk_addr_q);

    always_comb begin
        rdata = '0;
        case (off)
            REG_CTRL: begin
                rdata[CTRL_OVR]              = ovr_q;
                rdata[CTRL_CRST]             = crst_q;
                rdata[CTRL_RUN]              = run_q;
                rdata[CTRL_CS]               = cs_q;
                rdata[CTRL_K_LSB +: K_W]     = k_q;
            end
            REG_STEP: rdata[STEP_W-1:0] = step_q;
            REG_BRK: begin
                rdata[ROM_AW-1:0]            = brk_addr_q;
                rdata[BRK_EN_BIT]            = brk_en_q;
            end
            REG_STATUS: begin
                rdata[STAT_HALTED]           = dbg_halted_o;
                rdata[STAT_BRK_HIT]          = brk_hit_q;
                rdata[STAT_STEP_LSB +: STEP_W] = step_q;
            end
            REG_OUT: begin
                rdata[O_W-1:0]               = core_o_i;
                rdata[O_W +: R_W]            = core_r_i;
            end
            REG_CYC: rdata = cyc_q;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        ovr_d      = ovr_q;
        crst_d     = crst_q;
        run_d      = run_q;
        cs_d       = cs_q;
        k_d        = k_q;
        step_d     = step_q;
        brk_addr_d = brk_addr_q;
        brk_en_d   = brk_en_q;
        brk_hit_d  = brk_hit_q | brk_match;
        cyc_d      = core_run_o ? cyc_q + 32'd1 : cyc_q;
        dat_d      = accept ? rdata : dat_q;

        if (core_run_o && ovr_q && step_nz) begin
            step_d = step_q - STEP_W'(1);
        end

        // Bus writes are applied last so they win over same-cycle counter updates.
        if (wr) begin
            case (off)
                REG_CTRL: begin
                    ovr_d  = wbs_dat_i[CTRL_OVR];
                    crst_d = wbs_dat_i[CTRL_CRST];
                    run_d  = wbs_dat_i[CTRL_RUN];
                    cs_d   = wbs_dat_i[CTRL_CS];
                    k_d    = wbs_dat_i[CTRL_K_LSB +: K_W];
                    if (!wbs_dat_i[CTRL_OVR]) begin
                        step_d = '0;
                    end
                end
                REG_STEP: step_d = wbs_dat_i[STEP_W-1:0];
                REG_BRK: begin
                    brk_addr_d = wbs_dat_i[ROM_AW-1:0];
                    brk_en_d   = wbs_dat_i[BRK_EN_BIT];
                end
                REG_STATUS: begin
                    if (wbs_dat_i[STAT_BRK_HIT]) begin
                        brk_hit_d = brk_match;
                    end
                end
                REG_CYC: cyc_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ovr_q      <= 1'b0;
            crst_q     <= 1'b0;
            run_q      <= 1'b0;
            cs_q       <= 1'b0;
            k_q        <= '0;
            step_q     <= '0;
            brk_addr_q <= '0;
            brk_en_q   <= 1'b0;
            brk_hit_q  <= 1'b0;
            cyc_q      <= '0;
            dat_q      <= '0;
        end else begin
            ovr_q      <= ovr_d;
            crst_q     <= crst_d;
            run_q      <= run_d;
            cs_q       <= cs_d;
            k_q        <= k_d;
            step_q     <= step_d;
            brk_addr_q <= brk_addr_d;
            brk_en_q   <= brk_en_d;
            brk_hit_q  <= brk_hit_d;
            cyc_q      <= cyc_d;
            dat_q      <= dat_d;
        end
    end

endmodule

// File: tb/tb_mcu_wb_debug_ctrl.sv
// Randomised plus directed bench for mcu_wb_debug_ctrl against an in-bench reference model.
module tb_mcu_wb_debug_ctrl;

    localparam int K_W = 4, O_W = 8, R_W = 16, ROM_AW = 11, STEP_W = 16, ACK_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cyc, stb, we;
    logic [31:0]       adr, dat_i;
    logic [31:0]       dat_o;
    logic              ack;
    logic              pad_cs;
    logic [K_W-1:0]    pad_k;
    logic [O_W-1:0]    core_o;
    logic [R_W-1:0]    core_r;
    logic [ROM_AW-1:0] core_pc;
    logic              core_fetch;
    logic              core_rst, core_run, core_cs, halted;
    logic [K_W-1:0]    core_k;

    mcu_wb_debug_ctrl #(
        .K_W(K_W), .O_W(O_W), .R_W(R_W), .ROM_AW(ROM_AW), .STEP_W(STEP_W), .ACK_LAT(ACK_LAT)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .wbs_cyc_i       (cyc),
        .wbs_stb_i       (stb),
        .wbs_we_i        (we),
        .wbs_adr_i       (adr),
        .wbs_dat_i       (dat_i),
        .wbs_dat_o       (dat_o),
        .wbs_ack_o       (ack),
        .pad_chip_sel_i  (pad_cs),
        .pad_k_i         (pad_k),
        .core_o_i        (core_o),
        .core_r_i        (core_r),
        .core_pc_i       (core_pc),
        .core_fetch_i    (core_fetch),
        .core_rst_o      (core_rst),
        .core_run_o      (core_run),
        .core_chip_sel_o (core_cs),
        .core_k_o        (core_k),
        .dbg_halted_o    (halted)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_ovr, m_crst, m_run, m_cs, m_ben, m_hit;
    logic [3:0]  m_k;
    logic [15:0] m_step;
    logic [10:0] m_baddr;
    logic [31:0] m_cyc, m_rdata;
    int          m_age;

    function automatic logic m_core_rst();
        return !rst_n || (m_ovr && m_crst);
    endfunction

    function automatic logic m_core_run();
        if (m_core_rst() || m_hit) return 1'b0;
        if (!m_ovr) return 1'b1;
        return m_run || (m_step != 0);
    endfunction

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return {20'd0, m_k, 4'd0, m_cs, m_run, m_crst, m_ovr};
            1: return {16'd0, m_step};
            2: return {m_ben, 20'd0, m_baddr};
            3: return {8'd0, m_step, 6'd0, m_hit, !m_core_run() && !m_core_rst()};
            4: return {8'd0, core_r, core_o};
            5: return m_cyc;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_ovr, m_crst, m_run, m_cs, m_ben, m_hit} = '0;
            m_k = '0; m_step = '0; m_baddr = '0; m_cyc = '0; m_rdata = '0; m_age = 0;
        end else begin
            logic run_now, acc, hit;
            int off;
            run_now = m_core_run();
            acc     = cyc && stb && adr[23] && (m_age == 0);
            off     = int'(adr[4:2]);
            hit     = run_now && core_fetch && m_ben && (core_pc == m_baddr);
            if (acc) m_rdata = m_read(off);
            if (m_age != 0) m_age = (m_age == ACK_LAT) ? 0 : m_age + 1;
            else if (acc)   m_age = 1;
            if (run_now && m_ovr && m_step != 0) m_step = m_step - 1;
            if (run_now) m_cyc = m_cyc + 1;
            if (hit) m_hit = 1'b1;
            if (acc && we) begin
                case (off)
                    0: begin
                        m_ovr = dat_i[0]; m_crst = dat_i[1]; m_run = dat_i[2];
                        m_cs = dat_i[3]; m_k = dat_i[11:8];
                        if (!dat_i[0]) m_step = 0;
                    end
                    1: m_step = dat_i[15:0];
                    2: begin m_baddr = dat_i[10:0]; m_ben = dat_i[31]; end
                    3: if (dat_i[1] && !hit) m_hit = 1'b0;
                    5: m_cyc = 0;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int run_cnt = 0;
    always @(negedge clk) begin
        if (core_run) run_cnt++;
        chk("core_rst", {31'd0, core_rst}, {31'd0, m_core_rst()});
        chk("core_run", {31'd0, core_run}, {31'd0, m_core_run()});
        chk("halted", {31'd0, halted}, {31'd0, !m_core_run() && !m_core_rst()});
        chk("core_cs", {31'd0, core_cs}, {31'd0, m_ovr ? m_cs : pad_cs});
        chk("core_k", {28'd0, core_k}, {28'd0, m_ovr ? m_k : pad_k});
        chk("ack", {31'd0, ack}, {31'd0, (m_age == ACK_LAT)});
        chk("dat_o", dat_o, m_rdata);
    end

    // ---------------- stimulus helpers ----------------
    logic rand_io = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_io) begin
            pad_cs     = 1'($urandom);
            pad_k      = 4'($urandom);
            core_o     = 8'($urandom);
            core_r     = 16'($urandom);
            core_fetch = ($urandom_range(0, 2) == 0);
            core_pc    = 11'(32'h20 + $urandom_range(0, 7));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the ack cycle.
    task automatic wb_xfer(input logic w, input int off, input logic [31:0] d, input logic sel,
                           output logic [31:0] rd, output int lat);
        logic got;
        cyc = 1'b1; stb = 1'b1; we = w; dat_i = d;
        adr = 32'h3000_0000 | (sel ? 32'h0080_0000 : 32'h0) | (32'(off) << 2);
        rd = '0; lat = 0; got = 1'b0;
        @(posedge clk);
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (ack) begin got = 1'b1; rd = dat_o; end
        end
        if (sel) chk("ack_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        logic [31:0] rd; int lat;
        wb_xfer(1'b1, off, d, 1'b1, rd, lat);
    endtask

    task automatic rd_reg(input int off, output logic [31:0] rd);
        int lat;
        wb_xfer(1'b0, off, 32'h0, 1'b1, rd, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int lat, cnt0, guard;
        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0;
        pad_cs = 0; pad_k = 4'hA; core_o = 0; core_r = 0; core_pc = 0; core_fetch = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values and ack latency
        wb_xfer(1'b0, 0, 32'h0, 1'b1, rd, lat);
        chk("rst_ctrl", rd, 32'h0);
        chk("ack_latency", 32'(lat), 32'd2);
        rd_reg(3, rd); chk("rst_status", rd, 32'h0);
        rd_reg(5, rd);
        chk("free_run", {31'd0, core_run}, 32'd1);
        chk("k_from_pad", {28'd0, core_k}, 32'hA);

        // override and 3-step run
        wr_reg(0, 32'h0000_0501);
        chk("k_override", {28'd0, core_k}, 32'h5);
        wr_reg(5, 32'h0);
        cnt0 = run_cnt;
        wr_reg(1, 32'd3);
        idle(10);
        chk("step3_run_cycles", 32'(run_cnt - cnt0), 32'd3);
        rd_reg(3, rd); chk("step3_status", rd, 32'h1);
        rd_reg(5, rd); chk("step3_cyc", rd, 32'd3);

        // breakpoint
        wr_reg(0, 32'h0);
        wr_reg(2, 32'h8000_0024);
        core_fetch = 1'b1; core_pc = 11'h024;
        @(negedge clk); chk("brk_fetch_runs", {31'd0, core_run}, 32'd1);
        @(posedge clk); #1 core_fetch = 1'b0; core_pc = 11'h000;
        @(negedge clk); chk("brk_halt", {31'd0, core_run}, 32'd0);
        @(posedge clk); #1;
        rd_reg(3, rd); chk("brk_status", rd, 32'h3);
        wr_reg(3, 32'h2);
        chk("brk_resume", {31'd0, core_run}, 32'd1);

        // STEP write colliding with a decrement at step_cnt=2
        wr_reg(2, 32'h0);
        wr_reg(0, 32'h1);
        cnt0 = run_cnt;
        wr_reg(1, 32'd4);
        guard = 0;
        while (m_step != 16'd2 && guard < 20) begin idle(1); guard++; end
        chk("collide_reach2", 32'(m_step), 32'd2);
        wr_reg(1, 32'd10);
        idle(20);
        chk("collide_run_cycles", 32'(run_cnt - cnt0), 32'd13);

        // OUT and unmapped offsets
        core_o = 8'h5A; core_r = 16'h1234;
        rd_reg(4, rd); chk("out_reg", rd, 32'h0012_345A);
        wr_reg(6, 32'hFFFF_FFFF);
        rd_reg(6, rd); chk("off6_read", rd, 32'h0);
        rd_reg(0, rd); chk("off6_no_effect", rd, 32'h1);

        // reset in the middle of a transaction
        wr_reg(2, 32'h8000_0123);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0080_0004;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_core_rst_now", {31'd0, core_rst}, 32'd1);
        chk("rst_no_ack", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        idle(5);
        rst_n = 1'b1;
        rd_reg(0, rd); chk("post_rst_ctrl", rd, 32'h0);
        rd_reg(1, rd); chk("post_rst_step", rd, 32'h0);
        rd_reg(2, rd); chk("post_rst_brk", rd, 32'h0);
        rd_reg(3, rd); chk("post_rst_status", rd, 32'h0);

        // randomised traffic, checked cycle by cycle against the model
        rand_io = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int off;
            logic w, sel;
            logic [31:0] d;
            off = $urandom_range(0, 7);
            w   = 1'($urandom);
            sel = ($urandom_range(0, 9) != 0);
            d   = $urandom;
            case (off)
                0: d[1] = ($urandom_range(0, 7) == 0);
                1: d = 32'($urandom_range(0, 12)) | (d & 32'hFFFF_0000);
                2: d = (d & 32'h8000_0000) | (32'h20 + $urandom_range(0, 7));
                default: ;
            endcase
            wb_xfer(w, off, d, sel, rd, lat);
            idle($urandom_range(0, 3));
        end
        rand_io = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
